// File: rtl/diagnosis_trace_buffer.sv
// diagnosis_trace_buffer
//   Store-and-forward FIFO for trace packets coming out of the diagnosis
//   system debug NoC. A packet becomes readable only once its last (or
//   single) flit has been written. A packet that does not fit is rolled
//   back, dropped and counted in lost_count.
//
//   Optional feature, macro DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN:
//   after a drop, once the write side is idle and two slots are free, the
//   block stalls the input for two cycles and inserts a loss-report packet
//   {2'b01, LOSS_HDR}, {2'b10, lost_count}.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous, active-high reset
//   in_flit    : incoming flit, type in the top two bits
//                (01 header, 00 payload, 10 last, 11 single)
//   in_valid   : input handshake, flit offered
//   in_ready   : input handshake, flit accepted
//   out_flit   : FIFO head toward the debug NoC router
//   out_valid  : a committed flit is available
//   out_ready  : downstream accepts out_flit
//   lost_count : saturating count of dropped packets
//   fill_level : stored flits, committed plus tentative

module diagnosis_trace_buffer #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned FLIT_WIDTH = 18,
    parameter logic [15:0] LOSS_HDR   = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_WIDTH-1:0]  in_flit,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FLIT_WIDTH-1:0]  out_flit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            lost_count,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        DROP
    } state_t;

    typedef enum logic [1:0] {
        FT_PAYLOAD = 2'b00,
        FT_HEADER  = 2'b01,
        FT_LAST    = 2'b10,
        FT_SINGLE  = 2'b11
    } ftype_t;

    logic [FLIT_WIDTH-1:0] mem [DEPTH];

    state_t          state, state_nxt;
    ftype_t          ftype;
    logic [PW-1:0]   rd_ptr, wr_ptr, cmt_ptr;
    logic [PW-1:0]   wr_ptr_nxt, cmt_ptr_nxt;
    logic [PW-1:0]   used, used_cmt;
    logic            has_free, has_free_cmt;
    logic            wr_en;
    logic [PW-1:0]   wr_addr;
    logic [FLIT_WIDTH-1:0] wr_data;
    logic [1:0]      loss_inc;
    logic [16:0]     lost_sum;
    logic            idle_eval;
    logic [PW-1:0]   idle_base;
    logic            idle_room;
    logic            rep_start, rep_second;

    assign ftype        = ftype_t'(in_flit[FLIT_WIDTH-1 -: 2]);
    assign used         = wr_ptr - rd_ptr;
    assign used_cmt     = cmt_ptr - rd_ptr;
    assign has_free     = (used != PW'(DEPTH));
    assign has_free_cmt = (used_cmt != PW'(DEPTH));

    assign fill_level = used;
    assign out_valid  = (rd_ptr != cmt_ptr);
    assign out_flit   = mem[rd_ptr[AW-1:0]];
    assign in_ready   = !(rep_start || rep_second);

`ifdef DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN
    logic rep_pending;

    // Report needs two free slots because header and last go in back to back.
    assign rep_start = (state == IDLE) && rep_pending && !rep_second &&
                       (used <= PW'(DEPTH - 2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_pending <= 1'b0;
            rep_second  <= 1'b0;
        end else begin
            rep_second <= rep_start;
            if (loss_inc != 2'd0)
                rep_pending <= 1'b1;
            else if (rep_second)
                rep_pending <= 1'b0;
        end
    end
`else
    assign rep_start  = 1'b0;
    assign rep_second = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        cmt_ptr_nxt = cmt_ptr;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr;
        wr_data     = in_flit;
        loss_inc    = 2'd0;
        idle_eval   = 1'b0;
        idle_base   = wr_ptr;
        idle_room   = has_free;

        if (rep_start) begin
            wr_en      = 1'b1;
            wr_data    = FLIT_WIDTH'({FT_HEADER, LOSS_HDR});
            wr_ptr_nxt = wr_ptr + 1'b1;
        end else if (rep_second) begin
            wr_en       = 1'b1;
            wr_data     = FLIT_WIDTH'({FT_LAST, lost_count});
            wr_ptr_nxt  = wr_ptr + 1'b1;
            cmt_ptr_nxt = wr_ptr + 1'b1;
        end else if (in_valid && in_ready) begin
            unique case (state)
                IDLE: idle_eval = 1'b1;
                STORE: begin
                    case (ftype)
                        FT_PAYLOAD: begin
                            if (has_free) begin
                                wr_en      = 1'b1;
                                wr_ptr_nxt = wr_ptr + 1'b1;
                            end else begin
                                wr_ptr_nxt = cmt_ptr;
                                loss_inc   = 2'd1;
                                state_nxt  = DROP;
                            end
                        end
                        FT_LAST: begin
                            if (has_free) begin
                                wr_en       = 1'b1;
                                wr_ptr_nxt  = wr_ptr + 1'b1;
                                cmt_ptr_nxt = wr_ptr + 1'b1;
                            end else begin
                                wr_ptr_nxt = cmt_ptr;
                                loss_inc   = 2'd1;
                            end
                            state_nxt = IDLE;
                        end
                        default: begin
                            // Header/single inside an open packet: roll the open
                            // packet back, then evaluate the flit as in IDLE
                            // against the committed pointer and its free space.
                            wr_ptr_nxt = cmt_ptr;
                            loss_inc   = 2'd1;
                            state_nxt  = IDLE;
                            idle_eval  = 1'b1;
                            idle_base  = cmt_ptr;
                            idle_room  = has_free_cmt;
                        end
                    endcase
                end
                DROP: begin
                    if (ftype == FT_LAST || ftype == FT_SINGLE)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            if (idle_eval) begin
                wr_addr = idle_base;
                case (ftype)
                    FT_HEADER: begin
                        if (idle_room) begin
                            wr_en      = 1'b1;
                            wr_ptr_nxt = idle_base + 1'b1;
                            state_nxt  = STORE;
                        end else begin
                            loss_inc  = loss_inc + 2'd1;
                            state_nxt = DROP;
                        end
                    end
                    FT_SINGLE: begin
                        if (idle_room) begin
                            wr_en       = 1'b1;
                            wr_ptr_nxt  = idle_base + 1'b1;
                            cmt_ptr_nxt = idle_base + 1'b1;
                        end else begin
                            loss_inc = loss_inc + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lost_sum = {1'b0, lost_count} + {15'd0, loss_inc};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cmt_ptr    <= '0;
            lost_count <= '0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            cmt_ptr <= cmt_ptr_nxt;
            if (out_valid && out_ready)
                rd_ptr <= rd_ptr + 1'b1;
            lost_count <= lost_sum[16] ? '1 : lost_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr[AW-1:0]] <= wr_data;
    end

endmodule

// File: tb/tb_diagnosis_trace_buffer.sv
// Testbench for diagnosis_trace_buffer: directed packet scenarios plus a
// randomized run checked cycle by cycle against a packet-level queue model.
// Build with DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN to exercise the loss report.

module tb_diagnosis_trace_buffer;

    localparam int DEPTH = 32;
    localparam int FW    = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [15:0]   lost_count;
    logic [5:0]    fill_level;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    diagnosis_trace_buffer #(
        .DEPTH      (DEPTH),
        .FLIT_WIDTH (FW),
        .LOSS_HDR   (16'h0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .lost_count (lost_count),
        .fill_level (fill_level)
    );

    // ---------------- reference model (packet level) ----------------
    logic [17:0] exp_q[$];   // committed flits, readable in order
    logic [17:0] tent_q[$];  // flits of the open packet
    bit          m_open;
    bit          m_drop;
    int          m_lost;

    function automatic void model_clear();
        exp_q.delete();
        tent_q.delete();
        m_open = 0;
        m_drop = 0;
        m_lost = 0;
    endfunction

    function automatic void model_lose();
        if (m_lost < 65535) m_lost++;
    endfunction

    function automatic void model_input(input logic [17:0] f, input int occ_in);
        logic [1:0] t;
        int occ;
        t   = f[17:16];
        occ = occ_in;
        if (m_drop) begin
            if (t == 2'b10 || t == 2'b11) m_drop = 0;
            return;
        end
        if (m_open && (t == 2'b01 || t == 2'b11)) begin
            tent_q.delete();
            m_open = 0;
            model_lose();
            occ = exp_q.size();
        end
        if (m_open) begin
            if (occ >= DEPTH) begin
                tent_q.delete();
                m_open = 0;
                model_lose();
                if (t != 2'b10) m_drop = 1;
            end else begin
                tent_q.push_back(f);
                if (t == 2'b10) begin
                    foreach (tent_q[i]) exp_q.push_back(tent_q[i]);
                    tent_q.delete();
                    m_open = 0;
                end
            end
        end else if (t == 2'b01) begin
            if (occ < DEPTH) begin
                tent_q.push_back(f);
                m_open = 1;
            end else begin
                model_lose();
                m_drop = 1;
            end
        end else if (t == 2'b11) begin
            if (occ < DEPTH) exp_q.push_back(f);
            else model_lose();
        end
    endfunction

    // Drive one cycle from a negedge; returns at the following negedge.
    task automatic step(input logic [17:0] f, input logic v, input logic ordy);
        int occ;
        bit rd;
        in_flit   = f;
        in_valid  = v;
        out_ready = ordy;
        @(posedge clk);
        occ = exp_q.size() + tent_q.size();
        rd  = ordy && (exp_q.size() > 0);
        if (v) model_input(f, occ);
        if (rd) exp_q.delete(0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Flit i of packet p with length len (len==1 gives a single flit).
    function automatic logic [17:0] pf(input int p, input int i, input int len);
        logic [1:0] t;
        if (len == 1)           t = 2'b11;
        else if (i == 0)        t = 2'b01;
        else if (i == len - 1)  t = 2'b10;
        else                    t = 2'b00;
        return {t, 8'(p), 8'(i)};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_flit  = {2'b11, 16'h1234};
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (lost_count !== 16'd0) begin errors++; $display("FAIL reset_lost: got %0d want 0", lost_count); end
        checks++; if (fill_level !== 6'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (fill_level !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_held: fill %0d valid %b want 0 0", fill_level, out_valid); end
        rst      = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_single_packet();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(pf(1, i, 4), 1'b1, 1'b1);
            checks++;
            if (out_valid !== 1'((i == 3))) begin errors++; $display("FAIL sp_valid_after_%0d: got %b want %b", i, out_valid, (i == 3)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_flit !== pf(1, i, 4)) begin
                errors++; $display("FAIL sp_out_%0d: got %b/%h want 1/%h", i, out_valid, out_flit, pf(1, i, 4));
            end
            step('0, 1'b0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sp_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        for (int p = 0; p < 10; p++)
            for (int i = 0; i < 4; i++) step(pf(p, i, 4), 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd32) begin errors++; $display("FAIL of_fill: got %0d want 32", fill_level); end
        checks++; if (lost_count !== 16'd2) begin errors++; $display("FAIL of_lost: got %0d want 2", lost_count); end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (out_flit !== pf(n / 4, n % 4, 4)) begin errors++; $display("FAIL of_flit_%0d: got %h want %h", n, out_flit, pf(n / 4, n % 4, 4)); end
                n++;
            end
            step('0, 1'b0, 1'b1);
        end
        checks++; if (n !== 32) begin errors++; $display("FAIL of_count: got %0d want 32", n); end
    endtask

    task automatic test_rollback();
        int want_fill[5] = '{31, 32, 30, 30, 30};
        int n;
        do_reset();
        for (int p = 0; p < 7; p++)
            for (int i = 0; i < 4; i++) step(pf(p, i, 4), 1'b1, 1'b0);
        step(pf(7, 0, 2), 1'b1, 1'b0);
        step(pf(7, 1, 2), 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd30) begin errors++; $display("FAIL rb_fill30: got %0d want 30", fill_level); end
        for (int i = 0; i < 5; i++) begin
            step(pf(8, i, 5), 1'b1, 1'b0);
            checks++;
            if (fill_level !== 6'(want_fill[i])) begin errors++; $display("FAIL rb_fill_%0d: got %0d want %0d", i, fill_level, want_fill[i]); end
        end
        checks++; if (lost_count !== 16'd1) begin errors++; $display("FAIL rb_lost: got %0d want 1", lost_count); end
        n = 0;
        for (int c = 0; c < 36; c++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || out_flit !== exp_q[0] || out_flit[15:8] == 8'd8) begin
                    errors++; $display("FAIL rb_flit_%0d: got %h want model head", n, out_flit);
                end
                n++;
            end
            step('0, 1'b0, 1'b1);
        end
        checks++; if (n !== 30) begin errors++; $display("FAIL rb_count: got %0d want 30", n); end
    endtask

    task automatic test_protocol_error();
        do_reset();
        step({2'b00, 16'hFFFF}, 1'b1, 1'b0);
        step({2'b10, 16'hEEEE}, 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd0 || lost_count !== 16'd0) begin errors++; $display("FAIL pe_stray: fill %0d lost %0d want 0 0", fill_level, lost_count); end
        step(pf(10, 0, 4), 1'b1, 1'b0);
        step(pf(10, 1, 4), 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd2) begin errors++; $display("FAIL pe_open: got %0d want 2", fill_level); end
        step(pf(11, 0, 3), 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd1 || lost_count !== 16'd1) begin errors++; $display("FAIL pe_rollback: fill %0d lost %0d want 1 1", fill_level, lost_count); end
        step(pf(11, 1, 3), 1'b1, 1'b0);
        step(pf(11, 2, 3), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_flit !== pf(11, i, 3)) begin errors++; $display("FAIL pe_out_%0d: got %b/%h want 1/%h", i, out_valid, out_flit, pf(11, i, 3)); end
            step('0, 1'b0, 1'b1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pe_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(pf(20, 0, 4), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(pf(21, i, 3), 1'b1, 1'b0);
        step(pf(22, 0, 4), 1'b1, 1'b0);
        step(pf(22, 1, 4), 1'b1, 1'b0);
        checks++; if (fill_level !== 6'd5 || lost_count !== 16'd1) begin errors++; $display("FAIL mr_pre: fill %0d lost %0d want 5 1", fill_level, lost_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", out_valid); end
        checks++; if (fill_level !== 6'd0 || lost_count !== 16'd0) begin errors++; $display("FAIL mr_clear: fill %0d lost %0d want 0 0", fill_level, lost_count); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) step(pf(23, i, 3), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_flit !== pf(23, i, 3)) begin errors++; $display("FAIL mr_out_%0d: got %b/%h want 1/%h", i, out_valid, out_flit, pf(23, i, 3)); end
            step('0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        int rdy_pct = 50;
        int occ;
        int r;
        logic [1:0] t;
        logic v;
        logic ordy;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(5, 100);
            occ = exp_q.size() + tent_q.size();
            checks++;
            if (out_valid !== 1'((exp_q.size() != 0))) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++;
                if (out_flit !== exp_q[0]) begin errors++; $display("FAIL rnd_flit c%0d: got %h want %h", c, out_flit, exp_q[0]); end
            end
            checks++; if (fill_level !== 6'(occ)) begin errors++; $display("FAIL rnd_fill c%0d: got %0d want %0d", c, fill_level, occ); end
            checks++; if (lost_count !== 16'(m_lost)) begin errors++; $display("FAIL rnd_lost c%0d: got %0d want %0d", c, lost_count, m_lost); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_in_ready c%0d: got %b want 1", c, in_ready); end
            r = $urandom_range(0, 99);
            if (r < 20)      t = 2'b01;
            else if (r < 30) t = 2'b11;
            else if (r < 50) t = 2'b10;
            else             t = 2'b00;
            v    = ($urandom_range(0, 99) < 80);
            ordy = ($urandom_range(1, 100) <= rdy_pct);
            step({t, 16'($urandom)}, v, ordy);
        end
    endtask

`ifdef DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN
    task automatic test_loss_report();
        int lowc;
        logic [17:0] got[$];
        do_reset();
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 4; i++) step(pf(p, i, 4), 1'b1, 1'b0);
        step({2'b11, 16'h5555}, 1'b1, 1'b0);
        checks++; if (lost_count !== 16'd1) begin errors++; $display("FAIL lr_lost: got %0d want 1", lost_count); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        lowc = 0;
        for (int c = 0; c < 60; c++) begin
            if (in_ready === 1'b0) lowc++;
            if (out_valid === 1'b1) got.push_back(out_flit);
            @(negedge clk);
        end
        checks++; if (lowc !== 2) begin errors++; $display("FAIL lr_stall: got %0d cycles want 2", lowc); end
        checks++; if (got.size() !== 34) begin errors++; $display("FAIL lr_count: got %0d want 34", got.size()); end
        if (got.size() == 34) begin
            checks++; if (got[32] !== {2'b01, 16'h0000}) begin errors++; $display("FAIL lr_hdr: got %h want %h", got[32], {2'b01, 16'h0000}); end
            checks++; if (got[33] !== {2'b10, 16'h0001}) begin errors++; $display("FAIL lr_last: got %h want %h", got[33], {2'b10, 16'h0001}); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN
        test_single_packet();
        test_loss_report();
`else
        test_single_packet();
        test_overflow();
        test_rollback();
        test_protocol_error();
        test_mid_reset();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diagnosis_trace_buffer.md
DIAGNOSIS_TRACE_BUFFER -- requirements
Module: diagnosis_trace_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the FIFO depth in flits; it SHALL be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter FLIT_WIDTH, default 18, giving the flit width as 16 content bits plus 2 type bits.
REQ-003 The block SHALL have parameter LOSS_HDR, default 16'h0000, giving the content of the loss-report header flit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_flit, input, FLIT_WIDTH bits: trace flit from the diagnosis system debug NoC output.
REQ-007 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit) forming the input handshake.
REQ-008 The block SHALL have port out_flit, output, FLIT_WIDTH bits: flit toward the debug NoC router.
REQ-009 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit) forming the output handshake.
REQ-010 The block SHALL have port lost_count, output, 16 bits: cumulative count of dropped packets, saturating.
REQ-011 The block SHALL have port fill_level, output, log2(DEPTH)+1 bits: number of stored flits, committed plus tentative.

Function
REQ-012 Flit type SHALL be taken from bits [17:16], with 01 = header, 00 = payload, 10 = last, 11 = single.
REQ-013 A flit SHALL transfer when valid and ready are both high on a rising clk edge.
REQ-014 The buffer SHALL be store-and-forward: flits of a packet become readable only after its last or single flit is written (commit).
REQ-015 The write FSM SHALL have states IDLE, STORE and DROP.
REQ-016 In IDLE, a header with free slots of at least 1 SHALL be written and the FSM SHALL go to STORE.
REQ-017 In IDLE, a single flit with free slots of at least 1 SHALL be written and committed, and the FSM SHALL stay in IDLE.
REQ-018 In IDLE, a header or single flit arriving with free slots equal to 0 SHALL be discarded, lost_count SHALL be incremented, and the FSM SHALL go to DROP (header) or stay in IDLE (single).
REQ-019 In IDLE, payload and last flits SHALL be discarded silently, with no count.
REQ-020 In STORE, payload flits SHALL be written while space remains.
REQ-021 In STORE, a last flit SHALL be written, the tentative write pointer SHALL be committed, and the FSM SHALL return to IDLE.
REQ-022 In STORE, a flit arriving with free slots equal to 0 SHALL cause a rollback of the tentative pointer to the committed pointer and lost_count to increment. The FSM SHALL go to DROP, or to IDLE if that flit is a last.
REQ-023 In DROP, all flits SHALL be discarded until a last or single flit is seen; the FSM SHALL then go to IDLE.
REQ-024 A header or single flit seen in STORE SHALL be treated as a protocol error: the open packet is rolled back and counted as lost, then the flit is processed as if in IDLE.
REQ-025 Free slots SHALL be computed from occupancy at the start of the cycle; a slot freed by a same-cycle read SHALL NOT count.
REQ-026 in_ready SHALL be 1 in all states except during loss-report insertion (see Configuration).
REQ-027 out_valid SHALL be high whenever the read pointer differs from the committed pointer, and out_flit SHALL be the registered FIFO head.
REQ-028 Commit at edge N SHALL make out_valid high after edge N (zero-bubble) when the buffer was previously empty.
REQ-029 Read-side back-to-back transfers SHALL sustain 1 flit per cycle.
REQ-030 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-031 lost_count SHALL saturate at 16'hFFFF.

Reset
REQ-032 While rst is high, and asynchronously on its assertion, the following SHALL hold:
- out_valid = 0
- in_ready = 1
- lost_count = 0
- fill_level = 0
- all pointers = 0
- FSM = IDLE
- report-pending flag = 0
REQ-033 Reset mid-packet SHALL discard all stored and tentative flits without counting them as lost.

Configuration
REQ-034 Macro DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN SHALL control loss-report generation.
REQ-035 With DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN defined:
- Each drop SHALL set a report-pending flag.
- When the FSM is in IDLE, the flag is set, and free slots are at least 2, the block SHALL deassert in_ready for 2 cycles.
- In those cycles it SHALL write and commit a header {2'b01, LOSS_HDR}, then a last flit {2'b10, lost_count}, and then clear the flag.
REQ-036 Without DIAGNOSIS_TRACE_BUFFER_LOSS_REPORT_EN, no report flits SHALL be generated, in_ready SHALL be constant 1 after reset, and the loss is visible only on lost_count.

Verification
REQ-037 DEPTH=32, out_ready=1, 4-flit packet (header, 2 payload, last) -> out_valid rises the cycle after the last is accepted; 4 flits out in order on consecutive cycles.
REQ-038 out_ready=0, ten 4-flit packets -> 8 stored (fill_level=32); packets 9 and 10 dropped; lost_count=2; out_ready=1 -> exactly 32 flits, 8 complete packets.
REQ-039 Fill to 30 flits, then send a 5-flit packet -> rollback to fill_level=30; no partial flit ever appears on out; lost_count=1.
REQ-040 Stray payload in IDLE, then a header arriving mid-packet -> stray dropped uncounted; open packet rolled back (lost_count+1); new packet stored intact.
REQ-041 With LOSS_REPORT_EN, after one drop and the buffer draining -> in_ready low for 2 cycles; output {01,0000} then {10,0001}.
REQ-042 Assert rst during STORE with 3 committed flits -> out_valid=0, fill_level=0, lost_count=0 immediately; next packet passes normally.
